aes_enc_param: RTL and testbench

- Parametrised iterative AES encryption core supporting AES-128, AES-192 and AES-256 (selected by KEY_BITS).
- Full key expansion into an internal round-key store (one word per cycle), then one complete AES round per cycle.
- Start/ready handshake; optional reuse of the previously expanded key.
- Standalone encryption engine for the security subsystem.

---
 rtl/aes_enc_param.sv | 217 +++++++++++++++++++++
 tb/tb_aes_enc_param.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_param.sv
// Iterative AES encryption core (AES-128/192/256 chosen by KEY_BITS).
// The full key schedule is expanded into a local word store (one word per
// cycle); one complete round per cycle follows. An expanded key can be reused.
module aes_enc_param #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                key_reuse,
  input  logic [127:0]        din,
  input  logic [KEY_BITS-1:0] keyin,
  output logic                ready,
  output logic [127:0]        dout,
  output logic                dout_valid,
  output logic                done
);

  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned IW = $clog2(NW);
  localparam int unsigned RW = $clog2(NR + 1);

  // Only the three standard key sizes are meaningful
  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_enc_param: KEY_BITS must be 128, 192 or 256");
  end

  // FIPS-197 S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_ROUND} fsm_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[11'(2047) - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  // Byte n of the block sits at column n/4, row n%4
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  fsm_t          fsm;
  logic [31:0]   w [NW];
  logic [IW-1:0] i;
  logic [3:0]    ki;          // i mod NK, tracked incrementally
  logic [7:0]    rcon;
  logic [RW-1:0] r;
  logic          key_loaded;
  logic [127:0]  din_reg;
  logic [127:0]  st;

  logic          accept;
  logic          load_key;
  logic [31:0]   w_prev;
  logic [31:0]   w_far;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   t_word;
  logic [31:0]   w_new;
  logic [IW-1:0] rk_base;
  logic [127:0]  rk;
  logic [127:0]  sr;
  logic [127:0]  st_next;

  assign accept   = (fsm == S_IDLE) && start;
  assign load_key = accept && !(key_reuse && key_loaded);

  // Key schedule: next word from w[i-1] and w[i-NK]
  always_comb begin
    w_prev  = w[i - IW'(1)];
    w_far   = w[i - IW'(NK)];
    sub_in  = (ki == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = sub_word(sub_in);
    t_word  = w_prev;
    if (ki == 4'd0) begin
      t_word = sub_out ^ {rcon, 24'h0};
    end else if (NK == 8 && ki == 4'd4) begin
      t_word = sub_out;
    end
    w_new = w_far ^ t_word;
  end

  // Round datapath: initial AddRoundKey, full rounds, final round without MixColumns
  always_comb begin
    rk_base = IW'({r, 2'b00});
    rk      = {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};
    sr      = shift_rows(sub_bytes(st));
    if (r == RW'(0)) begin
      st_next = din_reg ^ rk;
    end else if (r == RW'(NR)) begin
      st_next = sr ^ rk;
    end else begin
      st_next = mix_columns(sr) ^ rk;
    end
  end

  // Round-key store: cipher key on accept, one expanded word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      if (load_key) begin
        for (int k = 0; k < NK; k++) begin
          w[k] <= keyin[KEY_BITS-1-32*k -: 32];
        end
      end else if (fsm == S_EXPAND) begin
        w[i] <= w_new;
      end
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm        <= S_IDLE;
      ready      <= 1'b1;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      key_loaded <= 1'b0;
      r          <= '0;
      i          <= '0;
      ki         <= '0;
      rcon       <= '0;
      din_reg    <= '0;
      st         <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start) begin
            din_reg    <= din;
            dout_valid <= 1'b0;
            ready      <= 1'b0;
            r          <= '0;
            if (key_reuse && key_loaded) begin
              fsm <= S_ROUND;
            end else begin
              key_loaded <= 1'b0;
              i          <= IW'(NK);
              ki         <= '0;
              rcon       <= 8'h01;
              fsm        <= S_EXPAND;
            end
          end
        end
        S_EXPAND: begin
          i  <= i + IW'(1);
          ki <= (ki == 4'(NK - 1)) ? 4'd0 : ki + 4'd1;
          if (ki == 4'd0) begin
            rcon <= xtime(rcon);
          end
          if (i == IW'(NW - 1)) begin
            key_loaded <= 1'b1;
            r          <= '0;
            fsm        <= S_ROUND;
          end
        end
        S_ROUND: begin
          st <= st_next;
          r  <= r + RW'(1);
          if (r == RW'(NR)) begin
            dout       <= st_next;
            dout_valid <= 1'b1;
            done       <= 1'b1;
            ready      <= 1'b1;
            r          <= '0;
            fsm        <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_param.sv
// Bench for aes_enc_param: one instance per key size, checked against a
// byte-array AES model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes_enc_param;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] KAT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_reuse;
  logic [127:0] din;
  logic [127:0] k128;
  logic [191:0] k192;
  logic [255:0] k256;
  logic         start_v [3];
  logic         ready_v [3];
  logic         dv_v    [3];
  logic         done_v  [3];
  logic [127:0] dout_v  [3];

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb_ref    [256];
  logic         mk_loaded [3];
  logic [255:0] mk        [3];

  always #5 clk = ~clk;

  aes_enc_param #(.KEY_BITS(128)) u_aes128 (
    .clk(clk), .rst(rst), .start(start_v[0]), .key_reuse(key_reuse), .din(din), .keyin(k128),
    .ready(ready_v[0]), .dout(dout_v[0]), .dout_valid(dv_v[0]), .done(done_v[0]));
  aes_enc_param #(.KEY_BITS(192)) u_aes192 (
    .clk(clk), .rst(rst), .start(start_v[1]), .key_reuse(key_reuse), .din(din), .keyin(k192),
    .ready(ready_v[1]), .dout(dout_v[1]), .dout_valid(dv_v[1]), .done(done_v[1]));
  aes_enc_param #(.KEY_BITS(256)) u_aes256 (
    .clk(clk), .rst(rst), .start(start_v[2]), .key_reuse(key_reuse), .din(din), .keyin(k256),
    .ready(ready_v[2]), .dout(dout_v[2]), .dout_valid(dv_v[2]), .done(done_v[2]));

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from multiplicative inverse (x^254) followed by the affine map
  task automatic build_sbox();
    logic [7:0] p, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      p = 8'h01;
      for (int e = 0; e < 254; e++) p = gmul(p, x);
      sb_ref[v] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
    end
  endtask

  // Textbook AES on a 16-byte array; key is left-aligned in 256 bits
  function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [127:0] o;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int k = 0; k < nk; k++) w[k] = key[255-32*k -: 32];
    for (int k = nk; k < 4*(nr+1); k++) begin
      tmp = w[k-1];
      if (k % nk == 0) begin
        tmp = {sb_ref[tmp[23:16]], sb_ref[tmp[15:8]], sb_ref[tmp[7:0]], sb_ref[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && k % nk == 4) begin
        tmp = {sb_ref[tmp[31:24]], sb_ref[tmp[23:16]], sb_ref[tmp[15:8]], sb_ref[tmp[7:0]]};
      end
      w[k] = w[k-nk] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int n = 0; n < 16; n++) s[n] = sb_ref[s[n]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd < nr) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction

  task automatic set_keys(input logic [255:0] key);
    k128 = key[255:128];
    k192 = key[255:64];
    k256 = key;
  endtask

  // One encryption on instance u; ends on the cycle done is high
  task automatic enc(input int u, input logic [255:0] key, input logic [127:0] pt,
                     input logic reuse, input bit poke, input string tag);
    int nk, nr, lat, n;
    logic use_old;
    logic [127:0] exp_ct;
    nk = 4 + 2*u;
    nr = nk + 6;
    use_old = reuse && mk_loaded[u];
    if (!use_old) mk[u] = key;
    lat = use_old ? nr + 1 : 4*(nr+1) - nk + nr + 1;
    exp_ct = aes_ref(mk[u], nk, pt);
    din = pt;
    key_reuse = reuse;
    set_keys(key);
    start_v[u] = 1'b1;
    step();
    start_v[u] = 1'b0;
    din = rand128();
    set_keys(rand256());
    key_reuse = 1'($urandom_range(0, 1));
    mk_loaded[u] = 1'b0;
    check_eq({tag, "_busy"}, 128'(ready_v[u]), 128'(0));
    check_eq({tag, "_dv_clr"}, 128'(dv_v[u]), 128'(0));
    n = 0;
    while (!dv_v[u] && n < 200) begin
      if (poke && (n == 4 || n == 29)) begin
        check_eq($sformatf("%s_poke%0d_ready", tag, n + 1), 128'(ready_v[u]), 128'(0));
        start_v[u] = 1'b1;
      end
      step();
      start_v[u] = 1'b0;
      n++;
    end
    check_eq({tag, "_latency"}, 128'(n), 128'(lat));
    check_eq({tag, "_dout"}, dout_v[u], exp_ct);
    check_eq({tag, "_done"}, 128'(done_v[u]), 128'(1));
    mk_loaded[u] = 1'b1;
  endtask

  task automatic check_reset_vals(input int u, input string tag);
    check_eq({tag, "_ready"}, 128'(ready_v[u]), 128'(1));
    check_eq({tag, "_dout"}, dout_v[u], 128'(0));
    check_eq({tag, "_dv"}, 128'(dv_v[u]), 128'(0));
    check_eq({tag, "_done"}, 128'(done_v[u]), 128'(0));
  endtask

  initial begin
    int u, prev_u, gap;
    logic [255:0] kk;
    build_sbox();
    rst = 1'b0;
    key_reuse = 1'b0;
    din = '0;
    set_keys('0);
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      mk_loaded[k] = 1'b0;
      mk[k] = '0;
    end
    step();
    step();
    for (int k = 0; k < 3; k++) check_reset_vals(k, $sformatf("reset_u%0d", k));
    rst = 1'b1;
    step();

    // Known-answer vectors; reuse right after reset must still expand
    kk = FIPS_KEY;
    enc(0, kk, FIPS_PT, 1'b1, 1'b0, "aes128_first");
    check_eq("aes128_kat", dout_v[0], KAT128);
    enc(0, rand256(), FIPS_PT, 1'b1, 1'b0, "aes128_b2b_reuse");
    check_eq("aes128_reuse_kat", dout_v[0], KAT128);
    step();
    check_eq("done_pulse_fall", 128'(done_v[0]), 128'(0));
    check_eq("dv_level_hold", 128'(dv_v[0]), 128'(1));
    enc(1, kk, FIPS_PT, 1'b0, 1'b0, "aes192_fips");
    check_eq("aes192_kat", dout_v[1], KAT192);
    enc(2, kk, FIPS_PT, 1'b0, 1'b0, "aes256_fips");
    check_eq("aes256_kat", dout_v[2], KAT256);
    step();

    // Starts while busy are ignored
    enc(0, rand256(), rand128(), 1'b0, 1'b1, "busy_poke");

    // Random keys, plaintexts, reuse flags and instances
    prev_u = 0;
    for (int it = 0; it < 16; it++) begin
      u = $urandom_range(0, 2);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        step();
        check_eq($sformatf("rnd%0d_done_fall", it), 128'(done_v[prev_u]), 128'(0));
        if (gap > 1) step();
      end
      enc(u, rand256(), rand128(), 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d_u%0d", it, u));
      prev_u = u;
    end
    step();

    // Reset in the middle of key expansion
    din = FIPS_PT;
    key_reuse = 1'b0;
    set_keys(kk);
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (20) step();
    check_eq("mid_expand_busy", 128'(ready_v[0]), 128'(0));
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_vals(0, "rst_expand");
    for (int k = 0; k < 3; k++) mk_loaded[k] = 1'b0;
    enc(0, kk, FIPS_PT, 1'b0, 1'b0, "after_rst_expand");
    check_eq("after_rst_expand_kat", dout_v[0], KAT128);
    step();

    // Reset in the middle of the rounds of a key-reuse run
    din = rand128();
    key_reuse = 1'b1;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (5) step();
    check_eq("mid_round_dout_stable", dout_v[0], KAT128);
    check_eq("mid_round_busy", 128'(ready_v[0]), 128'(0));
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_vals(0, "rst_round");
    for (int k = 0; k < 3; k++) mk_loaded[k] = 1'b0;
    enc(0, kk, FIPS_PT, 1'b1, 1'b0, "reuse_after_rst");
    check_eq("reuse_after_rst_kat", dout_v[0], KAT128);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
